nonogram_solver: RTL and testbench

//  Line-by-line nonogram constraint solver. A line FIFO streams a line index followed by that

---
 rtl/nonogram_solver.sv | 218 +++++++++++++++++++++
 tb/tb_nonogram_solver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonogram_solver.sv
// -----------------------------------------------------------------------------
// nonogram_solver
//
// Line-by-line nonogram constraint core. A line FIFO streams a line index
// followed by that line's candidate fill patterns, one per cycle. Candidates
// that contradict already-solved cells are dropped. Survivors are flagged for
// re-queueing and folded into AND/OR accumulators. At end of line, every cell
// on which all survivors agree becomes known.
//
// Ports
//   clk               system clock, all state on rising edge
//   rst               asynchronous, active-low reset
//   started           1-cycle pulse: clear board, begin solving
//   option            line index (low bits) in INDEX, candidate pattern in OPTS
//   num_rows          active rows (1..SIZE)
//   num_cols          active cols (1..SIZE)
//   old_options_amnt  candidate count per line; [r]=row r, [num_rows+c]=col c
//   new_line          high while a line index is expected on option
//   put_back_to_FIFO  current candidate is consistent (combinational, OPTS)
//   assigned          cell values, cell(r,c) at bit r*SIZE+c
//   known             cell-solved flags, same indexing
//   solved            all active cells known (registered)
// -----------------------------------------------------------------------------
module nonogram_solver #(
    parameter int SIZE = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   started,
    input  logic [SIZE-1:0]        option,
    input  logic [3:0]             num_rows,
    input  logic [3:0]             num_cols,
    input  logic [6:0]             old_options_amnt [2*SIZE],
    output logic                   new_line,
    output logic                   put_back_to_FIFO,
    output logic [SIZE*SIZE-1:0]   assigned,
    output logic [SIZE*SIZE-1:0]   known,
    output logic                   solved
);

    localparam int CELLS = SIZE * SIZE;
    localparam int CW    = $clog2(CELLS);     // flat cell address width
    localparam int IW    = $clog2(2 * SIZE);  // line index width

    typedef enum logic [1:0] {
        IDLE,
        INDEX,
        OPTS,
        UPDATE
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [6:0]      cnt;
    logic [SIZE-1:0] acc_and;
    logic [SIZE-1:0] acc_or;
    logic            any;

    // ------------------------------------------------------------------
    // Line decode: which board cells the latched index refers to
    // ------------------------------------------------------------------
    logic [IW-1:0]   rows_ext;
    logic [IW-1:0]   line_total;
    logic [IW-1:0]   col_sel;
    logic            is_row;
    logic            line_valid;
    logic [3:0]      line_len;
    logic [CW-1:0]   base;
    logic [CW-1:0]   stride;

    assign rows_ext   = IW'(num_rows);
    assign line_total = IW'(num_rows) + IW'(num_cols);
    assign is_row     = (idx < rows_ext);
    assign col_sel    = idx - rows_ext;
    // Indices past the last column, or past the board storage, touch nothing.
    assign line_valid = (idx < line_total) &&
                        (is_row ? (idx < IW'(SIZE)) : (col_sel < IW'(SIZE)));
    assign line_len   = is_row ? num_cols : num_rows;
    // A row walks consecutive bits; a column walks in steps of SIZE.
    assign base       = is_row ? (CW'(idx) * CW'(SIZE)) : CW'(col_sel);
    assign stride     = is_row ? CW'(1) : CW'(SIZE);

    // ------------------------------------------------------------------
    // Gather the line's board state and build the end-of-line update
    // ------------------------------------------------------------------
    logic [SIZE-1:0]  line_mask;
    logic [SIZE-1:0]  line_known;
    logic [SIZE-1:0]  line_val;
    logic [CELLS-1:0] upd_known;
    logic [CELLS-1:0] upd_assigned;
    logic [CW-1:0]    pos;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional write, otherwise synthesis infers latches.
        line_mask    = '0;
        line_known   = '0;
        line_val     = '0;
        upd_known    = known;
        upd_assigned = assigned;
        pos          = base;
        for (int j = 0; j < SIZE; j++) begin
            if (line_valid && (4'(j) < line_len)) begin
                line_mask[j]  = 1'b1;
                line_known[j] = known[pos];
                line_val[j]   = assigned[pos];
                // Unanimous survivors fix a cell; already-known cells stay put.
                if (!known[pos] && (acc_and[j] || !acc_or[j])) begin
                    upd_known[pos]    = 1'b1;
                    upd_assigned[pos] = acc_and[j];
                end
            end
            pos = pos + stride;
        end
    end

    logic consistent;
    assign consistent       = ~|((option ^ line_val) & line_known & line_mask);
    assign put_back_to_FIFO = (state == OPTS) && line_valid && consistent;

    // Candidate count for the index presented this cycle; out-of-table -> 0.
    logic [IW-1:0] opt_idx;
    logic [6:0]    start_cnt;
    assign opt_idx   = option[IW-1:0];
    assign start_cnt = (opt_idx < IW'(2 * SIZE)) ? old_options_amnt[opt_idx] : 7'd0;

    // ------------------------------------------------------------------
    // Active-region mask for the solved flag
    // ------------------------------------------------------------------
    logic [CELLS-1:0] active;

    for (genvar r = 0; r < SIZE; r++) begin : g_row
        for (genvar c = 0; c < SIZE; c++) begin : g_col
            assign active[r*SIZE+c] = (4'(r) < num_rows) && (4'(c) < num_cols);
        end
    end

    logic all_known;
    assign all_known = &(known | ~active);

    // ------------------------------------------------------------------
    // Control FSM and board state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the board is a flag array that must read "nothing known"
            // straight out of reset, so unlike a data RAM it is reset here.
            state    <= IDLE;
            new_line <= 1'b0;
            idx      <= '0;
            cnt      <= '0;
            acc_and  <= '1;
            acc_or   <= '0;
            any      <= 1'b0;
            known    <= '0;
            assigned <= '0;
        end else if (started) begin
            state    <= INDEX;
            new_line <= 1'b1;
            known    <= '0;
            assigned <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    new_line <= 1'b0;
                end

                INDEX: begin
                    idx      <= opt_idx;
                    cnt      <= start_cnt;
                    acc_and  <= '1;
                    acc_or   <= '0;
                    any      <= 1'b0;
                    new_line <= 1'b0;
                    state    <= (start_cnt == 7'd0) ? UPDATE : OPTS;
                end

                OPTS: begin
                    if (consistent) begin
                        acc_and <= acc_and & option;
                        acc_or  <= acc_or | option;
                        any     <= 1'b1;
                    end
                    cnt <= cnt - 7'd1;
                    if (cnt <= 7'd1) begin
                        state <= UPDATE;
                    end
                end

                UPDATE: begin
                    // No survivor means the line contradicts the board: leave it.
                    if (any) begin
                        known    <= upd_known;
                        assigned <= upd_assigned;
                    end
                    state    <= INDEX;
                    new_line <= 1'b1;
                end

                default: begin
                    state    <= IDLE;
                    new_line <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            solved <= 1'b0;
        end else begin
            solved <= all_known;
        end
    end

endmodule

// File: tb/tb_nonogram_solver.sv
// -----------------------------------------------------------------------------
// tb_nonogram_solver
//
// Directed bench for nonogram_solver on a 4x4 puzzle (SIZE=11). A table of
// per-cycle records {option, expected new_line, expected put_back, board tag}
// streams lines 0..7 plus an out-of-range index; tagged cycles compare the
// board against hand-built expectations. Hand-written sequences then cover a
// contradicting line, a started pulse mid-line and an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_nonogram_solver;

    localparam int SIZE  = 11;
    localparam int CELLS = SIZE * SIZE;

    logic                clk = 1'b0;
    logic                rst;
    logic                started;
    logic [SIZE-1:0]     option;
    logic [3:0]          num_rows;
    logic [3:0]          num_cols;
    logic [6:0]          amnt [2*SIZE];
    logic                new_line;
    logic                put_back_to_FIFO;
    logic [CELLS-1:0]    assigned;
    logic [CELLS-1:0]    known;
    logic                solved;

    nonogram_solver #(.SIZE(SIZE)) dut (
        .clk              (clk),
        .rst              (rst),
        .started          (started),
        .option           (option),
        .num_rows         (num_rows),
        .num_cols         (num_cols),
        .old_options_amnt (amnt),
        .new_line         (new_line),
        .put_back_to_FIFO (put_back_to_FIFO),
        .assigned         (assigned),
        .known            (known),
        .solved           (solved)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Board image from four 4-bit rows, bit c of a row = cell(r,c).
    function automatic logic [CELLS-1:0] board(input logic [3:0] r0, input logic [3:0] r1,
                                               input logic [3:0] r2, input logic [3:0] r3);
        logic [CELLS-1:0] b;
        b        = '0;
        b[3:0]   = r0;
        b[14:11] = r1;
        b[25:22] = r2;
        b[36:33] = r3;
        return b;
    endfunction

    // One cycle: drive on the falling edge, sample 1 ns later.
    task automatic cyc(input logic [SIZE-1:0] opt, input logic st);
        @(negedge clk);
        option  = opt;
        started = st;
        #1;
    endtask

    typedef struct {
        logic [SIZE-1:0] opt;
        logic            nl;
        logic            pb;
        int              tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [SIZE-1:0] opt, input logic nl, input logic pb, input int tag);
        vec_t v;
        v.opt = opt;
        v.nl  = nl;
        v.pb  = pb;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic idx_cyc(input int i, input int tag);
        add(SIZE'(i), 1'b1, 1'b0, tag);
    endtask

    task automatic opt_cyc(input logic [3:0] o, input logic pb);
        add(SIZE'(o), 1'b0, pb, 0);
    endtask

    task automatic upd_cyc();
        add('0, 1'b0, 1'b0, 0);
    endtask

    logic [CELLS-1:0] sol_a, all_k, row3_k, row3_a, col0_k, col0_a;

    initial begin
        sol_a  = board(4'b1100, 4'b0011, 4'b0101, 4'b1101);
        all_k  = board(4'hf, 4'hf, 4'hf, 4'hf);
        row3_k = board(4'h0, 4'h0, 4'h0, 4'hf);
        row3_a = board(4'h0, 4'h0, 4'h0, 4'b1101);
        col0_k = board(4'b0001, 4'b0001, 4'b0001, 4'hf);
        col0_a = board(4'h0, 4'b0001, 4'b0001, 4'b1101);

        for (int i = 0; i < 2*SIZE; i++) amnt[i] = 7'd0;
        amnt[0] = 7'd3; amnt[1] = 7'd3; amnt[2] = 7'd3; amnt[3] = 7'd1;
        amnt[4] = 7'd2; amnt[5] = 7'd4; amnt[6] = 7'd1; amnt[7] = 7'd3;
        amnt[8] = 7'd2;  // out-of-range line (8 >= 4+4) still carries candidates

        // Stream table: lines 0..7 then line 8, one record per cycle.
        idx_cyc(0, 0); opt_cyc(4'b0011, 1); opt_cyc(4'b0110, 1); opt_cyc(4'b1100, 1); upd_cyc();
        idx_cyc(1, 1); opt_cyc(4'b0011, 1); opt_cyc(4'b0110, 1); opt_cyc(4'b1100, 1); upd_cyc();
        idx_cyc(2, 0); opt_cyc(4'b0101, 1); opt_cyc(4'b1001, 1); opt_cyc(4'b1010, 1); upd_cyc();
        idx_cyc(3, 2); opt_cyc(4'b1101, 1); upd_cyc();
        idx_cyc(4, 3); opt_cyc(4'b1110, 1); opt_cyc(4'b0111, 0); upd_cyc();
        idx_cyc(5, 4); opt_cyc(4'b0010, 1); opt_cyc(4'b1000, 0); opt_cyc(4'b1100, 0);
                       opt_cyc(4'b1001, 0); upd_cyc();
        idx_cyc(6, 0); opt_cyc(4'b1101, 1); upd_cyc();
        idx_cyc(7, 0); opt_cyc(4'b1001, 1); opt_cyc(4'b0011, 0); opt_cyc(4'b0101, 0); upd_cyc();
        idx_cyc(8, 5); opt_cyc(4'b1111, 0); opt_cyc(4'b0000, 0); upd_cyc();
        idx_cyc(0, 6);

        // Reset state
        rst      = 1'b0;
        started  = 1'b0;
        option   = '0;
        num_rows = 4'd4;
        num_cols = 4'd4;
        repeat (2) @(negedge clk);
        #1;
        check("reset known", 128'(known), 128'(0));
        check("reset assigned", 128'(assigned), 128'(0));
        check("reset solved", 128'(solved), 128'(0));
        check("reset new_line", 128'(new_line), 128'(0));
        check("reset put_back", 128'(put_back_to_FIFO), 128'(0));
        rst = 1'b1;

        cyc('0, 1'b0);
        check("idle new_line", 128'(new_line), 128'(0));
        cyc('0, 1'b1);  // started pulse; INDEX follows

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].opt, 1'b0);
            check($sformatf("v%0d new_line", i), 128'(new_line), 128'(vecs[i].nl));
            check($sformatf("v%0d put_back", i), 128'(put_back_to_FIFO), 128'(vecs[i].pb));
            case (vecs[i].tag)
                1: check("after row0 known", 128'(known), 128'(0));
                2: begin
                    check("before row3 known", 128'(known), 128'(0));
                    check("before row3 assigned", 128'(assigned), 128'(0));
                end
                3: begin
                    check("after row3 known", 128'(known), 128'(row3_k));
                    check("after row3 assigned", 128'(assigned), 128'(row3_a));
                end
                4: begin
                    check("after col0 known", 128'(known), 128'(col0_k));
                    check("after col0 assigned", 128'(assigned), 128'(col0_a));
                    check("after col0 solved", 128'(solved), 128'(0));
                end
                5: begin
                    check("full known", 128'(known), 128'(all_k));
                    check("full assigned", 128'(assigned), 128'(sol_a));
                end
                6: begin
                    check("idx8 known", 128'(known), 128'(all_k));
                    check("idx8 assigned", 128'(assigned), 128'(sol_a));
                    check("final solved", 128'(solved), 128'(1));
                end
                default: ;
            endcase
        end

        // started while row 0 candidates are streaming: board cleared, INDEX next
        cyc(11'b0011, 1'b1);
        cyc(11'd3, 1'b0);
        check("restart new_line", 128'(new_line), 128'(1));
        check("restart known", 128'(known), 128'(0));
        check("restart assigned", 128'(assigned), 128'(0));
        cyc(11'b1101, 1'b0);
        check("restart row3 put_back", 128'(put_back_to_FIFO), 128'(1));
        check("restart solved", 128'(solved), 128'(0));
        cyc('0, 1'b0);
        cyc(11'd4, 1'b0);
        check("row3 again known", 128'(known), 128'(row3_k));

        // Contradiction: both col0 candidates clash with cell(3,0)=1
        cyc(11'b0111, 1'b0);
        check("contra opt0 put_back", 128'(put_back_to_FIFO), 128'(0));
        cyc(11'b0000, 1'b0);
        check("contra opt1 put_back", 128'(put_back_to_FIFO), 128'(0));
        cyc('0, 1'b0);
        cyc(11'd5, 1'b0);
        check("contra new_line", 128'(new_line), 128'(1));
        check("contra known", 128'(known), 128'(row3_k));
        check("contra assigned", 128'(assigned), 128'(row3_a));

        // started mid-line on col1
        cyc(11'b0010, 1'b0);
        check("col1 opt0 put_back", 128'(put_back_to_FIFO), 128'(1));
        cyc(11'b0100, 1'b0);
        check("col1 opt1 put_back", 128'(put_back_to_FIFO), 128'(1));
        cyc(11'b0001, 1'b1);
        cyc(11'd3, 1'b0);
        check("midline start new_line", 128'(new_line), 128'(1));
        check("midline start known", 128'(known), 128'(0));
        check("midline start assigned", 128'(assigned), 128'(0));
        cyc(11'b1101, 1'b0);
        check("post start put_back", 128'(put_back_to_FIFO), 128'(1));
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        check("post start known", 128'(known), 128'(row3_k));
        check("post start new_line", 128'(new_line), 128'(1));

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("async rst known", 128'(known), 128'(0));
        check("async rst assigned", 128'(assigned), 128'(0));
        check("async rst new_line", 128'(new_line), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
